// File: rtl/caravel_reset_seq_pkg.sv
// caravel_reset_seq_pkg
// Shared types and defaults for the staged reset release sequencer.
//   seq_state_e    : FSM state encoding, also exported on seq_state
//   DEF_NUM_STAGES : default number of reset domains
//   DEF_CNT_W      : default gap counter width
package caravel_reset_seq_pkg;

    localparam int DEF_NUM_STAGES = 4;
    localparam int DEF_CNT_W      = 8;

    // Encodings are fixed because software/debug reads them through seq_state.
    typedef enum logic [2:0] {
        ST_RST       = 3'd0,
        ST_WAIT      = 3'd1,
        ST_DONE      = 3'd2,
        ST_SOFT_HOLD = 3'd3,
        ST_SOFT_ACK  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/caravel_reset_seq_gapcnt.sv
// caravel_reset_seq_gapcnt
// Loadable down-counter timing the gap between domain releases.
//   i_clk      : clock
//   i_rst_n    : async active-low reset (count clears to 0)
//   i_load     : load i_load_val (has priority over i_dec)
//   i_load_val : value to load
//   i_dec      : decrement by one, holds at zero
//   o_zero     : count is zero (decoded from the register only)
module caravel_reset_seq_gapcnt
    import caravel_reset_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/caravel_reset_seq.sv
// caravel_reset_seq
// Releases a vector of per-domain active-low resets one at a time, in index
// order, with a programmable gap. Optional soft reset (build macro
// RSTSEQ_SOFT_RST_EN) re-asserts a masked subset of domains and re-sequences
// them under a 4-phase req/ack handshake.
//   ext_clk       : system clock
//   resetb        : async active-low reset
//   stage_gap     : N gives N+1 cycles between releases (sampled per sequence)
//   soft_rst_req  : soft reset request, level
//   soft_rst_mask : domains affected by the soft reset
//   soft_rst_ack  : soft reset complete, level (tied 0 without the macro)
//   rst_n_out     : per-domain active-low resets
//   seq_done      : all domains released, nothing in progress
//   seq_state     : current FSM state
//
// state     | meaning
// ----------+----------------------------------------------------------
// RST       | held in reset; leaves on first clock with resetb high
// WAIT      | counting gaps, releasing one index per expired gap
// DONE      | all domains released, idle
// SOFT_HOLD | masked domains asserted, waiting one gap before re-release
// SOFT_ACK  | soft sequence finished, ack held until req drops
module caravel_reset_seq
    import caravel_reset_seq_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  ext_clk,
    input  logic                  resetb,
    input  logic [CNT_W-1:0]      stage_gap,
    input  logic                  soft_rst_req,
    input  logic [NUM_STAGES-1:0] soft_rst_mask,
    output logic                  soft_rst_ack,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  seq_done,
    output logic [2:0]            seq_state
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    seq_state_e            r_state;
    seq_state_e            w_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [CNT_W-1:0]      r_gap_q;
    logic [CNT_W-1:0]      w_gap_nxt;
    logic [NUM_STAGES-1:0] r_rst_n;
    logic [NUM_STAGES-1:0] w_rst_n_nxt;
    logic                  r_seq_done;
    logic                  w_done_nxt;
    logic [NUM_STAGES-1:0] w_rel_set;

    logic                  w_cnt_load;
    logic [CNT_W-1:0]      w_cnt_load_val;
    logic                  w_cnt_dec;
    logic                  w_cnt_zero;

`ifdef RSTSEQ_SOFT_RST_EN
    logic [NUM_STAGES-1:0] r_mask_q;
    logic [NUM_STAGES-1:0] w_mask_nxt;
    logic [NUM_STAGES-1:0] r_rel_set;
    logic [NUM_STAGES-1:0] w_rel_nxt;
    logic                  r_soft_seq;
    logic                  w_soft_nxt;
    logic                  r_ack;
    logic                  w_ack_nxt;

    assign w_rel_set = r_rel_set;
`else
    logic w_unused_soft;

    // Without soft reset every sequence releases every domain.
    assign w_rel_set     = '1;
    assign w_unused_soft = ^{soft_rst_req, soft_rst_mask};
`endif

    caravel_reset_seq_gapcnt #(
        .CNT_W (CNT_W)
    ) u_gapcnt (
        .i_clk      (ext_clk),
        .i_rst_n    (resetb),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_gap_nxt      = r_gap_q;
        w_rst_n_nxt    = r_rst_n;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = r_gap_q;
        w_cnt_dec      = 1'b0;
`ifdef RSTSEQ_SOFT_RST_EN
        w_mask_nxt     = r_mask_q;
        w_rel_nxt      = r_rel_set;
        w_soft_nxt     = r_soft_seq;
`endif
        case (r_state)
            ST_RST: begin
                w_state_nxt    = ST_WAIT;
                w_gap_nxt      = stage_gap;
                w_cnt_load     = 1'b1;
                w_cnt_load_val = stage_gap;
                w_idx_nxt      = '0;
                w_rst_n_nxt    = '0;
`ifdef RSTSEQ_SOFT_RST_EN
                w_rel_nxt      = '1;
                w_soft_nxt     = 1'b0;
`endif
            end
            ST_WAIT: begin
                if (w_cnt_zero) begin
                    // Skipped indices still consume their gap slot.
                    if (w_rel_set[r_idx]) begin
                        w_rst_n_nxt[r_idx] = 1'b1;
                    end
                    if (r_idx == LAST_IDX) begin
`ifdef RSTSEQ_SOFT_RST_EN
                        w_state_nxt = r_soft_seq ? ST_SOFT_ACK : ST_DONE;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end else begin
                        w_idx_nxt  = r_idx + 1'b1;
                        w_cnt_load = 1'b1;
                    end
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
`ifdef RSTSEQ_SOFT_RST_EN
                if (soft_rst_req) begin
                    w_state_nxt    = ST_SOFT_HOLD;
                    w_mask_nxt     = soft_rst_mask;
                    w_gap_nxt      = stage_gap;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = stage_gap;
                    w_rst_n_nxt    = r_rst_n & ~soft_rst_mask;
                end
`endif
            end
`ifdef RSTSEQ_SOFT_RST_EN
            ST_SOFT_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_WAIT;
                    w_idx_nxt   = '0;
                    w_rel_nxt   = r_mask_q;
                    w_soft_nxt  = 1'b1;
                    w_cnt_load  = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_SOFT_ACK: begin
                if (!soft_rst_req) begin
                    w_state_nxt = ST_DONE;
                    w_soft_nxt  = 1'b0;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_RST;
            end
        endcase
    end

    // Status flags are registered from the next state so they change on the
    // same edge as the state itself.
    assign w_done_nxt = (w_state_nxt == ST_DONE) || (w_state_nxt == ST_SOFT_ACK);

    always_ff @(posedge ext_clk or negedge resetb) begin
        if (!resetb) begin
            r_state    <= ST_RST;
            r_idx      <= '0;
            r_gap_q    <= '0;
            r_rst_n    <= '0;
            r_seq_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_gap_q    <= w_gap_nxt;
            r_rst_n    <= w_rst_n_nxt;
            r_seq_done <= w_done_nxt;
        end
    end

`ifdef RSTSEQ_SOFT_RST_EN
    assign w_ack_nxt = (w_state_nxt == ST_SOFT_ACK);

    always_ff @(posedge ext_clk or negedge resetb) begin
        if (!resetb) begin
            r_mask_q   <= '0;
            r_rel_set  <= '1;
            r_soft_seq <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_mask_q   <= w_mask_nxt;
            r_rel_set  <= w_rel_nxt;
            r_soft_seq <= w_soft_nxt;
            r_ack      <= w_ack_nxt;
        end
    end

    assign soft_rst_ack = r_ack;
`else
    assign soft_rst_ack = 1'b0;
`endif

    assign rst_n_out = r_rst_n;
    assign seq_done  = r_seq_done;
    assign seq_state = r_state;

endmodule

// File: tb/tb_caravel_reset_seq.sv
module tb_caravel_reset_seq;

    logic       ext_clk = 1'b0;
    logic       resetb  = 1'b1;
    logic [7:0] stage_gap = 8'd0;
    logic       soft_rst_req = 1'b0;
    logic [3:0] soft_rst_mask = 4'd0;
    logic       soft_rst_ack;
    logic [3:0] rst_n_out;
    logic       seq_done;
    logic [2:0] seq_state;

    int n_checks = 0;
    int n_fail   = 0;

    caravel_reset_seq #(
        .NUM_STAGES (4),
        .CNT_W      (8)
    ) dut (
        .ext_clk       (ext_clk),
        .resetb        (resetb),
        .stage_gap     (stage_gap),
        .soft_rst_req  (soft_rst_req),
        .soft_rst_mask (soft_rst_mask),
        .soft_rst_ack  (soft_rst_ack),
        .rst_n_out     (rst_n_out),
        .seq_done      (seq_done),
        .seq_state     (seq_state)
    );

    always #5 ext_clk = ~ext_clk;

    typedef struct {
        string      name;
        int         gap;
        int         k;      // posedges after posedge 0
        logic [3:0] rst;
        logic       done;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] rst, input logic done,
                           input logic ack, input logic [2:0] st);
        chk({name, ".rst"},   32'(rst_n_out),    32'(rst));
        chk({name, ".done"},  32'(seq_done),     32'(done));
        chk({name, ".ack"},   32'(soft_rst_ack), 32'(ack));
        chk({name, ".state"}, 32'(seq_state),    32'(st));
    endtask

    // Returns at posedge 0 (first posedge with resetb high).
    task automatic powerup(input int gap);
        @(negedge ext_clk);
        resetb    = 1'b0;
        stage_gap = 8'(gap);
        @(negedge ext_clk);
        resetb = 1'b1;
        @(posedge ext_clk);
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge ext_clk);
        #1;
    endtask

    task automatic wait_ack(input string name, input int budget);
        int n;
        n = 0;
        while (soft_rst_ack !== 1'b1 && n < budget) begin
            @(posedge ext_clk);
            #1;
            n++;
        end
        chk({name, ".ack_wait"}, 32'(soft_rst_ack), 32'd1);
    endtask

    initial begin
        vecs.push_back('{"g3_k0",    3,   0, 4'b0000, 1'b0, 3'd1});
        vecs.push_back('{"g3_k3",    3,   3, 4'b0000, 1'b0, 3'd1});
        vecs.push_back('{"g3_k4",    3,   4, 4'b0001, 1'b0, 3'd1});
        vecs.push_back('{"g3_k7",    3,   7, 4'b0001, 1'b0, 3'd1});
        vecs.push_back('{"g3_k8",    3,   8, 4'b0011, 1'b0, 3'd1});
        vecs.push_back('{"g3_k12",   3,  12, 4'b0111, 1'b0, 3'd1});
        vecs.push_back('{"g3_k15",   3,  15, 4'b0111, 1'b0, 3'd1});
        vecs.push_back('{"g3_k16",   3,  16, 4'b1111, 1'b1, 3'd2});
        vecs.push_back('{"g0_k1",    0,   1, 4'b0001, 1'b0, 3'd1});
        vecs.push_back('{"g0_k2",    0,   2, 4'b0011, 1'b0, 3'd1});
        vecs.push_back('{"g0_k3",    0,   3, 4'b0111, 1'b0, 3'd1});
        vecs.push_back('{"g0_k4",    0,   4, 4'b1111, 1'b1, 3'd2});
        vecs.push_back('{"g255_k255", 255, 255, 4'b0000, 1'b0, 3'd1});
        vecs.push_back('{"g255_k256", 255, 256, 4'b0001, 1'b0, 3'd1});

        // Reset state
        #2 resetb = 1'b0;
        adv(2);
        chk_all("reset", 4'b0000, 1'b0, 1'b0, 3'd0);

        // Power-up release timing
        for (int i = 0; i < vecs.size(); i++) begin
            powerup(vecs[i].gap);
            adv(vecs[i].k);
            chk_all(vecs[i].name, vecs[i].rst, vecs[i].done, 1'b0, vecs[i].st);
        end

        // stage_gap change mid-sequence is ignored
        powerup(3);
        adv(5);
        stage_gap = 8'd0;
        adv(3);
        chk_all("gapchg_k8", 4'b0011, 1'b0, 1'b0, 3'd1);
        adv(8);
        chk_all("gapchg_k16", 4'b1111, 1'b1, 1'b0, 3'd2);

        // resetb pulsed low mid-sequence
        powerup(3);
        adv(9);
        chk_all("midseq_k9", 4'b0011, 1'b0, 1'b0, 3'd1);
        #2 resetb = 1'b0;
        #1;
        chk_all("midseq_async", 4'b0000, 1'b0, 1'b0, 3'd0);
        powerup(3);
        adv(4);
        chk_all("midseq_restart", 4'b0001, 1'b0, 1'b0, 3'd1);

`ifdef RSTSEQ_SOFT_RST_EN
        // Soft reset, mask 1010, gap 2
        powerup(2);
        adv(12);
        chk_all("soft_pre", 4'b1111, 1'b1, 1'b0, 3'd2);
        soft_rst_mask = 4'b1010;
        soft_rst_req  = 1'b1;
        adv(1);
        chk_all("soft_p0", 4'b0101, 1'b0, 1'b0, 3'd3);
        adv(8);
        chk_all("soft_p8", 4'b0101, 1'b0, 1'b0, 3'd1);
        adv(1);
        chk_all("soft_p9", 4'b0111, 1'b0, 1'b0, 3'd1);
        adv(5);
        chk_all("soft_p14", 4'b0111, 1'b0, 1'b0, 3'd1);
        adv(1);
        chk_all("soft_p15", 4'b1111, 1'b1, 1'b1, 3'd4);
        adv(3);
        chk_all("soft_ackhold", 4'b1111, 1'b1, 1'b1, 3'd4);
        soft_rst_req = 1'b0;
        adv(1);
        chk_all("soft_ackdrop", 4'b1111, 1'b1, 1'b0, 3'd2);

        // Request during initial sequence waits for DONE
        powerup(1);
        adv(2);
        soft_rst_mask = 4'b1111;
        soft_rst_req  = 1'b1;
        adv(3);
        chk_all("early_k5", 4'b0011, 1'b0, 1'b0, 3'd1);
        adv(3);
        chk_all("early_k8", 4'b1111, 1'b1, 1'b0, 3'd2);
        adv(1);
        chk_all("early_k9", 4'b0000, 1'b0, 1'b0, 3'd3);
        wait_ack("early", 40);
        chk("early.rst_after", 32'(rst_n_out), 32'hf);
        soft_rst_req = 1'b0;
        adv(1);
        chk_all("early_drop", 4'b1111, 1'b1, 1'b0, 3'd2);

        // Empty mask: ack without output change
        soft_rst_mask = 4'b0000;
        soft_rst_req  = 1'b1;
        adv(1);
        chk_all("mask0_p0", 4'b1111, 1'b0, 1'b0, 3'd3);
        wait_ack("mask0", 40);
        chk("mask0.rst_after", 32'(rst_n_out), 32'hf);
        soft_rst_req = 1'b0;
        adv(1);
        chk_all("mask0_drop", 4'b1111, 1'b1, 1'b0, 3'd2);

        // resetb pulsed low during SOFT_HOLD
        powerup(3);
        adv(16);
        soft_rst_mask = 4'b1111;
        soft_rst_req  = 1'b1;
        adv(2);
        chk_all("hold_in", 4'b0000, 1'b0, 1'b0, 3'd3);
        #2 resetb = 1'b0;
        #1;
        chk_all("hold_async", 4'b0000, 1'b0, 1'b0, 3'd0);
        soft_rst_req = 1'b0;
        powerup(0);
        adv(4);
        chk_all("hold_restart", 4'b1111, 1'b1, 1'b0, 3'd2);
`else
        // Soft reset compiled out: requests are ignored
        powerup(0);
        adv(4);
        soft_rst_mask = 4'b1111;
        soft_rst_req  = 1'b1;
        adv(3);
        chk_all("nosoft_req1", 4'b1111, 1'b1, 1'b0, 3'd2);
        soft_rst_req = 1'b0;
        adv(2);
        soft_rst_req = 1'b1;
        adv(6);
        chk_all("nosoft_req2", 4'b1111, 1'b1, 1'b0, 3'd2);
        soft_rst_req = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
